// File: rtl/envelope_generator.sv
// Attack/sustain/release envelope generator.
// A free-running counter produces a one-clk sample tick every 2^SAMPLECLOCK_DIV
// clks. On each tick the envelope FSM adds the attack rate or subtracts the
// release rate, saturating at full scale or zero. The upper bits of the
// accumulator are presented as the 8-bit volume.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no note; acc held at zero, waiting for gate on a tick
//   ATTACK  | gate high; acc += a per tick, saturating at full scale
//   SUSTAIN | gate high; acc held at full scale
//   RELEASE | gate low; acc -= r per tick, reaching zero returns to IDLE

module envelope_generator #(
    parameter int SAMPLECLOCK_DIV = 8,
    parameter int BITDEPTH        = 14,
    parameter int BITFRACTION     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gate,
    input  logic [7:0] a,
    input  logic [7:0] r,
    output logic       sample_clock,
    output logic [7:0] volume
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [BITDEPTH-1:0] FULL_SCALE = '1;

    logic [SAMPLECLOCK_DIV-1:0] counter;
    state_t                     state_q, state_d;
    logic [BITDEPTH-1:0]        acc_q, acc_d;

    // Rates widened to accumulator width plus one guard bit.
    logic [BITDEPTH:0] a_ext, r_ext, sum, diff;
    logic [BITDEPTH-1:0] add_sat, sub_sat;

    assign a_ext = {{(BITDEPTH - 7){1'b0}}, a};
    assign r_ext = {{(BITDEPTH - 7){1'b0}}, r};
    assign sum   = {1'b0, acc_q} + a_ext;
    assign diff  = {1'b0, acc_q} - r_ext;

    // The guard bit flags overflow on add and borrow on subtract.
    assign add_sat = sum[BITDEPTH]  ? FULL_SCALE : sum[BITDEPTH-1:0];
    assign sub_sat = diff[BITDEPTH] ? '0         : diff[BITDEPTH-1:0];

    // Sample tick: counter wraps freely; strobe is registered off the all-ones count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter      <= '0;
            sample_clock <= 1'b0;
        end else begin
            counter      <= counter + SAMPLECLOCK_DIV'(1);
            sample_clock <= &counter;
        end
    end

    // Envelope state, accumulator and volume registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            volume  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            volume  <= acc_d[BITDEPTH-1:BITFRACTION];
        end
    end

    // Next-state and accumulator update, evaluated only on a sample tick.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (sample_clock) begin
            unique case (state_q)
                IDLE: begin
                    acc_d = '0;
                    if (gate) begin
                        acc_d   = add_sat;
                        state_d = (add_sat == FULL_SCALE) ? SUSTAIN : ATTACK;
                    end
                end
                ATTACK, RELEASE: begin
                    if (gate) begin
                        // Re-gating during release resumes from the current level.
                        acc_d   = add_sat;
                        state_d = (add_sat == FULL_SCALE) ? SUSTAIN : ATTACK;
                    end else begin
                        acc_d   = sub_sat;
                        state_d = (sub_sat == '0) ? IDLE : RELEASE;
                    end
                end
                SUSTAIN: begin
                    if (gate) begin
                        acc_d = FULL_SCALE;
                    end else begin
                        acc_d   = sub_sat;
                        state_d = (sub_sat == '0) ? IDLE : RELEASE;
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_envelope_generator.sv
// Testbench for envelope_generator. A default-parameter instance checks the
// tick timing; a fast-tick instance runs the envelope against a reference model.
module tb_envelope_generator;

    localparam int FS = 16383;

    logic       clk = 1'b0;
    logic       rst_n, gate, gate_def;
    logic [7:0] a, r;
    logic       sc_d, sc_f;
    logic [7:0] vol_d, vol_f;

    always #5 clk = ~clk;

    envelope_generator dut_def (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate_def),
        .a            (a),
        .r            (r),
        .sample_clock (sc_d),
        .volume       (vol_d)
    );

    envelope_generator #(.SAMPLECLOCK_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .a            (a),
        .r            (r),
        .sample_clock (sc_f),
        .volume       (vol_f)
    );

    typedef struct {
        logic       g;
        logic [7:0] a;
        logic [7:0] r;
        int         n;
        logic [7:0] exp_vol;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    // Reference model: 0 idle, 1 attack, 2 sustain, 3 release.
    int m_acc = 0;
    int m_st  = 0;

    function automatic void model_step();
        if (m_st == 0) begin
            if (gate) begin
                m_acc = int'(a);
                m_st  = 1;
            end
        end else if (gate) begin
            if (m_st != 2) begin
                m_acc = m_acc + int'(a);
                if (m_acc >= FS) begin
                    m_acc = FS;
                    m_st  = 2;
                end else begin
                    m_st = 1;
                end
            end
        end else begin
            m_acc = m_acc - int'(r);
            if (m_acc <= 0) begin
                m_acc = 0;
                m_st  = 0;
            end else begin
                m_st = 3;
            end
        end
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Wait for the next fast tick, predict its result, then compare after the update edge.
    task automatic do_tick();
        int         w;
        logic [7:0] e;
        w = 0;
        while (sc_f !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (sc_f !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_timeout got=%0d exp=1", sc_f);
            return;
        end
        model_step();
        exp_q.push_back(8'(m_acc >> 6));
        @(negedge clk);
        e = exp_q.pop_front();
        check_int("tick_volume", int'(vol_f), int'(e));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, pat_err, verr, first_d, first_f;

        vecs.push_back('{1'b1, 8'd220, 8'd0,   74,  8'd254});
        vecs.push_back('{1'b1, 8'd220, 8'd0,   1,   8'd255});
        vecs.push_back('{1'b1, 8'd220, 8'd0,   20,  8'd255});
        vecs.push_back('{1'b0, 8'd0,   8'd60,  100, 8'd162});
        vecs.push_back('{1'b0, 8'd0,   8'd60,  173, 8'd0});
        vecs.push_back('{1'b0, 8'd0,   8'd60,  1,   8'd0});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  163, 8'd254});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  1,   8'd255});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  148, 8'd255});
        vecs.push_back('{1'b0, 8'd100, 8'd60,  274, 8'd0});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  50,  8'd78});
        vecs.push_back('{1'b0, 8'd100, 8'd60,  1,   8'd77});
        vecs.push_back('{1'b0, 8'd100, 8'd60,  10,  8'd67});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  1,   8'd69});
        vecs.push_back('{1'b1, 8'd100, 8'd60,  5,   8'd77});
        vecs.push_back('{1'b1, 8'd0,   8'd60,  3,   8'd77});
        vecs.push_back('{1'b0, 8'd0,   8'd0,   3,   8'd77});
        vecs.push_back('{1'b0, 8'd0,   8'd255, 20,  8'd0});
        vecs.push_back('{1'b1, 8'd255, 8'd0,   65,  8'd255});

        rst_n    = 1'b0;
        gate     = 1'b0;
        gate_def = 1'b0;
        a        = 8'd0;
        r        = 8'd0;
        repeat (3) @(negedge clk);
        check_int("reset_sc_def",  int'(sc_d),  0);
        check_int("reset_vol_def", int'(vol_d), 0);
        check_int("reset_sc_fast", int'(sc_f),  0);
        check_int("reset_vol_fast", int'(vol_f), 0);
        rst_n = 1'b1;

        // Idle timing on the default instance: pulses on clk edges 256, 512, 768, 1024.
        pulses  = 0;
        pat_err = 0;
        verr    = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk);
            #1;
            if (sc_d !== ((k % 256) == 0)) pat_err++;
            if (sc_d === 1'b1) pulses++;
            if (vol_d !== 8'd0) verr++;
        end
        check_int("idle_pulse_count",   pulses,  4);
        check_int("idle_pulse_pattern", pat_err, 0);
        check_int("idle_volume",        verr,    0);
        @(negedge clk);

        foreach (vecs[i]) begin
            gate = vecs[i].g;
            a    = vecs[i].a;
            r    = vecs[i].r;
            for (int t = 0; t < vecs[i].n; t++) do_tick();
            check_int($sformatf("vec%0d_final", i), int'(vol_f), int'(vecs[i].exp_vol));
        end

        // Reset pulse during sustain aborts the note and restarts the tick counters.
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        gate  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_int("rst_mid_vol_fast", int'(vol_f), 0);
        check_int("rst_mid_sc_fast",  int'(sc_f),  0);
        check_int("rst_mid_sc_def",   int'(sc_d),  0);
        m_acc = 0;
        m_st  = 0;
        exp_q.delete();
        first_d = 0;
        first_f = 0;
        for (int c = 1; c <= 300 && first_d == 0; c++) begin
            @(posedge clk);
            #1;
            if (sc_d === 1'b1 && first_d == 0) first_d = c;
            if (sc_f === 1'b1 && first_f == 0) first_f = c;
        end
        check_int("restart_first_tick_def",  first_d, 256);
        check_int("restart_first_tick_fast", first_f, 16);
        check_int("restart_vol_fast",        int'(vol_f), 0);
        @(negedge clk);
        do_tick();
        gate = 1'b1;
        a    = 8'd255;
        do_tick();
        check_int("new_note_after_reset", int'(vol_f), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
